// File: rtl/qif_neuron_scheduler.sv
// Time-shared QIF neuron array: one membrane-update datapath swept over N_NEURONS
// stored states, spike indices queued in a small FIFO with a valid/ready port.
module qif_neuron_scheduler #(
  parameter int               N_NEURONS  = 4,
  parameter logic signed [7:0] V_PEAK    = 8'sd50,
  parameter logic signed [7:0] V_RESET   = -8'sd20,
  parameter int               FIFO_DEPTH = 4,
  localparam int              IW         = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          b_we,
  input  logic [IW-1:0] b_idx,
  input  logic [7:0]    b_data,
  input  logic [IW-1:0] mon_idx,
  output logic [7:0]    mon_v,
  output logic          spk_valid,
  input  logic          spk_ready,
  output logic [IW-1:0] spk_idx,
  output logic          busy,
  output logic          sweep_done,
  output logic          tick_miss,
  output logic          spk_ovf
);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, DONE = 2'd2} state_t;

  state_t            state_r, state_next_s;
  logic [IW-1:0]     ptr_r;
  logic signed [7:0] v_r [N_NEURONS];
  logic signed [7:0] b_r [N_NEURONS];
  logic [7:0]        mon_v_r;
  logic              busy_r, sweep_done_r, tick_miss_r, spk_ovf_r, spk_valid_r;
  logic [IW-1:0]     fifo_r [FIFO_DEPTH];
  logic [CW-1:0]     count_r, count_next_s;

  logic signed [7:0]  v_cur_s, b_cur_s, v_next_s;
  logic signed [15:0] sq_s;
  logic signed [12:0] sum_s;
  logic               last_s, spike_s, pop_s, full_s, push_ok_s;
  logic [FW-1:0]      wr_idx_s;

  function automatic logic signed [7:0] sat8(input logic signed [12:0] x);
    if (x > 13'sd127) begin
      sat8 = 8'sd127;
    end else if (x < -13'sd128) begin
      sat8 = -8'sd128;
    end else begin
      sat8 = x[7:0];
    end
  endfunction

  // Membrane update for the neuron currently addressed by the sweep pointer
  always_comb begin
    v_cur_s = v_r[ptr_r];
    b_cur_s = b_r[ptr_r];
    sq_s    = v_cur_s * v_cur_s;
    sum_s   = 13'(v_cur_s) + 13'(b_cur_s >>> 2) + 13'(sq_s >>> 4);
    if (v_cur_s >= V_PEAK) begin
      v_next_s = V_RESET;
    end else begin
      v_next_s = sat8(sum_s);
    end
    spike_s = (state_r == UPDATE) && (v_cur_s >= V_PEAK);
    last_s  = (ptr_r == IW'(N_NEURONS - 1));
  end

  // Sweep sequencing
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = tick ? UPDATE : IDLE;
      UPDATE:  state_next_s = last_s ? DONE : UPDATE;
      DONE:    state_next_s = tick ? UPDATE : IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FIFO push/pop arbitration; a push into a full FIFO survives only with a same-cycle pop
  always_comb begin
    pop_s     = spk_valid_r && spk_ready;
    full_s    = (count_r == CW'(FIFO_DEPTH));
    push_ok_s = spike_s && (!full_s || pop_s);
    if (pop_s) begin
      wr_idx_s = FW'(count_r - CW'(1'b1));
    end else begin
      wr_idx_s = FW'(count_r);
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1'b1);
      2'b01:   count_next_s = count_r - CW'(1'b1);
      default: count_next_s = count_r;
    endcase
  end

  // Control registers and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      ptr_r        <= {IW{1'b0}};
      busy_r       <= 1'b0;
      sweep_done_r <= 1'b0;
      tick_miss_r  <= 1'b0;
      spk_ovf_r    <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      if (state_r == UPDATE && !last_s) begin
        ptr_r <= ptr_r + IW'(1'b1);
      end else begin
        ptr_r <= {IW{1'b0}};
      end
      busy_r       <= (state_next_s == UPDATE);
      sweep_done_r <= (state_next_s == DONE);
      tick_miss_r  <= tick_miss_r | (tick && state_r == UPDATE);
      spk_ovf_r    <= spk_ovf_r | (spike_s && !push_ok_s);
    end
  end

  // Neuron state, drive registers and the monitor port (shows same-edge updates)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_r[i] <= V_RESET;
        b_r[i] <= 8'sd0;
      end
      mon_v_r <= V_RESET;
    end else begin
      if (state_r == UPDATE) begin
        v_r[ptr_r] <= v_next_s;
      end
      if (b_we) begin
        b_r[b_idx] <= b_data;
      end
      if (state_r == UPDATE && ptr_r == mon_idx) begin
        mon_v_r <= v_next_s;
      end else begin
        mon_v_r <= v_r[mon_idx];
      end
    end
  end

  // Shift-register spike FIFO: entry 0 is always the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_r[i] <= {IW{1'b0}};
      end
      count_r     <= {CW{1'b0}};
      spk_valid_r <= 1'b0;
    end else begin
      if (pop_s) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
          fifo_r[i] <= fifo_r[i+1];
        end
      end
      if (push_ok_s) begin
        fifo_r[wr_idx_s] <= ptr_r;
      end
      count_r     <= count_next_s;
      spk_valid_r <= (count_next_s != {CW{1'b0}});
    end
  end

  assign mon_v      = mon_v_r;
  assign spk_valid  = spk_valid_r;
  assign spk_idx    = fifo_r[0];
  assign busy       = busy_r;
  assign sweep_done = sweep_done_r;
  assign tick_miss  = tick_miss_r;
  assign spk_ovf    = spk_ovf_r;

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Directed bench for qif_neuron_scheduler: per-sweep vector tables plus
// hand-written sequences for overflow, missed ticks, DONE-cycle ticks and reset.
module tb_qif_neuron_scheduler;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       b_we = 1'b0;
  logic [1:0] b_idx = 2'd0;
  logic [7:0] b_data = 8'd0;
  logic [1:0] mon_idx = 2'd0;
  logic [7:0] mon_v;
  logic       spk_valid;
  logic       spk_ready = 1'b1;
  logic [1:0] spk_idx;
  logic       busy, sweep_done, tick_miss, spk_ovf;

  int n_chk = 0;
  int n_fail = 0;
  int ev_q[$];
  int done_cnt = 0;
  int base, dbase;

  typedef struct {
    logic [1:0]        mon;
    logic signed [7:0] exp_v;
    int                exp_ev;
  } vec_t;
  vec_t tab_a[4];
  vec_t tab_b[8];
  vec_t tab_g[3];

  qif_neuron_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .b_we(b_we), .b_idx(b_idx), .b_data(b_data),
    .mon_idx(mon_idx), .mon_v(mon_v), .spk_valid(spk_valid), .spk_ready(spk_ready),
    .spk_idx(spk_idx), .busy(busy), .sweep_done(sweep_done), .tick_miss(tick_miss),
    .spk_ovf(spk_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && spk_valid && spk_ready) ev_q.push_back(int'(spk_idx));
    if (!rst && sweep_done) done_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; b_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_b(input logic [1:0] idx, input logic [7:0] data);
    b_we = 1'b1; b_idx = idx; b_data = data;
    @(negedge clk);
    b_we = 1'b0;
  endtask

  task automatic read_mon(input logic [1:0] idx, input int exp, input string name);
    mon_idx = idx;
    @(negedge clk);
    check(name, int'($signed(mon_v)), exp);
  endtask

  // Pulses tick from the current negedge and returns at the sweep_done negedge.
  task automatic do_sweep(input int wr_k, input logic [1:0] wr_idx, input logic [7:0] wr_data);
    int k;
    bit seen;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    k = 1;
    seen = 1'b0;
    check("busy_after_tick", int'(busy), 1);
    check("done_low_first", int'(sweep_done), 0);
    while (k <= 20 && !seen) begin
      if (sweep_done) begin
        seen = 1'b1;
      end else begin
        if (k == wr_k) begin
          b_we = 1'b1; b_idx = wr_idx; b_data = wr_data;
        end else begin
          b_we = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    b_we = 1'b0;
    check("sweep_latency", seen ? k : -1, N + 1);
    check("busy_in_done", int'(busy), 0);
  endtask

  task automatic finish_idle();
    @(negedge clk);
    check("done_one_cycle", int'(sweep_done), 0);
    check("idle_busy", int'(busy), 0);
  endtask

  initial begin
    tab_a[0] = '{2'd0, 8'sd15, 0};
    tab_a[1] = '{2'd0, 8'sd39, 0};
    tab_a[2] = '{2'd0, 8'sd127, 0};
    tab_a[3] = '{2'd0, -8'sd20, 1};
    tab_b[0] = '{2'd0, 8'sd5, 0};
    tab_b[1] = '{2'd1, 8'sd6, 0};
    tab_b[2] = '{2'd2, 8'sd8, 0};
    tab_b[3] = '{2'd3, 8'sd12, 0};
    tab_b[4] = '{2'd0, 8'sd21, 0};
    tab_b[5] = '{2'd1, 8'sd48, 0};
    tab_b[6] = '{2'd2, 8'sd127, 0};
    tab_b[7] = '{2'd3, -8'sd20, 4};
    tab_g[0] = '{2'd1, -8'sd27, 0};
    tab_g[1] = '{2'd1, -8'sd14, 0};
    tab_g[2] = '{2'd1, -8'sd34, 0};

    // reset state
    do_reset();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(sweep_done), 0);
    check("rst_valid", int'(spk_valid), 0);
    check("rst_spk_idx", int'(spk_idx), 0);
    check("rst_tick_miss", int'(tick_miss), 0);
    check("rst_ovf", int'(spk_ovf), 0);
    for (int i = 0; i < N; i++) read_mon(2'(i), -20, "rst_mon_v");

    // B[0] = 40, four sweeps
    write_b(2'd0, 8'd40);
    base = ev_q.size();
    for (int i = 0; i < 4; i++) begin
      do_sweep(0, 2'd0, 8'd0);
      finish_idle();
      read_mon(tab_a[i].mon, int'(tab_a[i].exp_v), "vec_a_v");
      check("vec_a_events", ev_q.size() - base, tab_a[i].exp_ev);
    end
    if (ev_q.size() > base) check("vec_a_ev_idx", ev_q[base], 0);

    // B all zero, eight sweeps, all spike on the eighth
    do_reset();
    base = ev_q.size();
    dbase = done_cnt;
    for (int i = 0; i < 8; i++) begin
      do_sweep(0, 2'd0, 8'd0);
      finish_idle();
      read_mon(tab_b[i].mon, int'(tab_b[i].exp_v), "vec_b_v");
      check("vec_b_events", ev_q.size() - base, tab_b[i].exp_ev);
    end
    check("vec_b_done_cnt", done_cnt - dbase, 8);
    for (int i = 0; i < 4; i++)
      if (ev_q.size() > base + i) check("vec_b_ev_order", ev_q[base + i], i);

    // FIFO fill and overflow with consumer stalled (B = 127: spikes on sweeps 3 and 6)
    do_reset();
    spk_ready = 1'b0;
    for (int i = 0; i < N; i++) write_b(2'(i), 8'd127);
    base = ev_q.size();
    for (int s = 1; s <= 6; s++) begin
      do_sweep(0, 2'd0, 8'd0);
      finish_idle();
      if (s == 3) begin
        check("fifo_full_valid", int'(spk_valid), 1);
        check("fifo_head_idx", int'(spk_idx), 0);
        check("fifo_full_no_ovf", int'(spk_ovf), 0);
      end
    end
    check("fifo_ovf_set", int'(spk_ovf), 1);
    spk_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("drain_count", ev_q.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (ev_q.size() > base + i) check("drain_order", ev_q[base + i], i);
    check("drain_empty", int'(spk_valid), 0);
    check("ovf_sticky", int'(spk_ovf), 1);

    // refill FIFO, then reset in the middle of a sweep (ptr = 2)
    spk_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      do_sweep(0, 2'd0, 8'd0);
      finish_idle();
    end
    check("refill_valid", int'(spk_valid), 1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(spk_valid), 0);
    check("midrst_ovf", int'(spk_ovf), 0);
    check("midrst_mon_v", int'($signed(mon_v)), -20);
    @(negedge clk);
    rst = 1'b0;
    spk_ready = 1'b1;
    for (int i = 0; i < N; i++) read_mon(2'(i), -20, "midrst_v");
    do_sweep(0, 2'd0, 8'd0);
    finish_idle();
    read_mon(2'd0, 5, "midrst_b_cleared");
    check("midrst_no_events", int'(spk_valid), 0);

    // tick two cycles into a sweep is dropped and flagged
    dbase = done_cnt;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("tick_miss_set", int'(tick_miss), 1);
    begin
      int k = 0;
      while (k < 20 && !sweep_done) begin
        @(negedge clk);
        k++;
      end
      check("miss_sweep_ends", int'(sweep_done), 1);
    end
    repeat (10) @(negedge clk);
    check("miss_one_sweep", done_cnt - dbase, 1);
    read_mon(2'd0, 6, "miss_v");

    // tick during DONE starts the next sweep back to back
    dbase = done_cnt;
    do_sweep(0, 2'd0, 8'd0);
    do_sweep(0, 2'd0, 8'd0);
    finish_idle();
    check("done_tick_sweeps", done_cnt - dbase, 2);
    read_mon(2'd0, 12, "done_tick_v");
    check("tick_miss_sticky", int'(tick_miss), 1);

    // negative drive, B write during evaluation, same-edge monitor
    do_reset();
    base = ev_q.size();
    write_b(2'd1, 8'h80);
    for (int i = 0; i < 3; i++) begin
      do_sweep(0, 2'd0, 8'd0);
      finish_idle();
      read_mon(tab_g[i].mon, int'(tab_g[i].exp_v), "vec_g_v");
      check("vec_g_events", ev_q.size() - base, tab_g[i].exp_ev);
    end
    do_sweep(3, 2'd2, 8'd127);
    finish_idle();
    read_mon(2'd2, 12, "b_write_old_b");
    do_sweep(0, 2'd0, 8'd0);
    finish_idle();
    read_mon(2'd2, 52, "b_write_new_b");
    read_mon(2'd0, 21, "n0_sweep5");
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("mon_before_update", int'($signed(mon_v)), 21);
    @(negedge clk);
    check("mon_same_edge", int'($signed(mon_v)), 48);
    begin
      int k = 0;
      while (k < 20 && !sweep_done) begin
        @(negedge clk);
        k++;
      end
      check("sweep6_ends", int'(sweep_done), 1);
    end
    repeat (3) @(negedge clk);
    check("vec_g_spike_count", ev_q.size() - base, 1);
    if (ev_q.size() > base) check("vec_g_spike_idx", ev_q[base], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
